// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder for the core's data bus.
// Serves byte/half/word loads and stores from a word array after a
// programmable number of wait states, then ACKs for one cycle.
// Ports:
//   clk, reset      - clock and synchronous active-high reset
//   DAD             - byte address, captured with the request
//   DDT             - bidirectional data, right-aligned, driven only
//                     in the ACK cycle of a load
//   MREQ, WRITE     - request strobe and store/load select
//   SIZE            - 00 byte, 01 half, 10/11 word
//   ACKD_n          - active-low completion strobe
//   ERR             - completing access is faulty (DMEM_ERR_EN only)
// Optional feature macro: DMEM_ERR_EN (alignment/range fault checking
// and the ERR port); without it low address bits below the access
// size are ignored and addresses wrap modulo DEPTH_WORDS.
module dmem_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          DEPTH_WORDS = 4096,
    parameter int          WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] DAD,
    inout  wire  [31:0] DDT,
    input  logic        MREQ,
    input  logic        WRITE,
    input  logic [1:0]  SIZE,
    output logic        ACKD_n
`ifdef DMEM_ERR_EN
    ,
    output logic        ERR
`endif
);

    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACK
    } state_t;

    state_t state, state_nx;

    logic [3:0]    cnt;
    logic [AW-1:0] idx_q;
    logic [1:0]    lane_q;
    logic [1:0]    size_q;
    logic          write_q;
    logic [31:0]   wdata_q;
    logic          fault_q;

    logic [31:0] mem [DEPTH_WORDS];

    // Request decode, evaluated on the live bus at capture time
    logic [31:0] off;
    logic [1:0]  lane;
    logic        fault;

    assign off = DAD - BASE_ADDR;

    // Index bits wrap naturally; only the range check uses the top bits
    logic unused_off;
    assign unused_off = ^off[31:AW+2];

    always_comb begin
        lane = 2'b00;
        case (SIZE)
            2'b00:   lane = off[1:0];
            2'b01:   lane = {off[1], 1'b0};
            default: lane = 2'b00;
        endcase
    end

    always_comb begin
        fault = 1'b0;
`ifdef DMEM_ERR_EN
        if ({32'd0, off} >= (64'(DEPTH_WORDS) << 2))
            fault = 1'b1;
        if (SIZE == 2'b01 && off[0])
            fault = 1'b1;
        if (SIZE[1] && off[1:0] != 2'b00)
            fault = 1'b1;
`endif
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:
                if (MREQ)
                    state_nx = (WAIT_CYCLES == 0) ? S_ACK : S_WAIT;
            S_WAIT:
                if (cnt == 4'(WAIT_CYCLES - 1))
                    state_nx = S_ACK;
            S_ACK:
                state_nx = S_IDLE;
            default:
                state_nx = S_IDLE;
        endcase
    end

    // Wait counter and request holding registers
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= 4'd0;
            fault_q <= 1'b0;
            write_q <= 1'b0;
        end else begin
            cnt <= (state == S_WAIT) ? cnt + 4'd1 : 4'd0;
            if (state == S_IDLE && MREQ) begin
                idx_q   <= off[AW+1:2];
                lane_q  <= lane;
                size_q  <= SIZE;
                write_q <= WRITE;
                wdata_q <= DDT;
                fault_q <= fault;
            end
        end
    end

    // Byte-enabled store; reset in the ACK cycle suppresses the commit
    logic [3:0]  be;
    logic [31:0] sdata;
    logic        we;

    always_comb begin
        be = 4'b1111;
        case (size_q)
            2'b00:   be = 4'b0001 << lane_q;
            2'b01:   be = 4'b0011 << lane_q;
            default: be = 4'b1111;
        endcase
    end

    assign sdata = wdata_q << {lane_q, 3'b000};
    assign we    = (state == S_ACK) && write_q && !fault_q && !reset;

    always_ff @(posedge clk) begin
        if (we)
            for (int i = 0; i < 4; i++)
                if (be[i])
                    mem[idx_q][8*i +: 8] <= sdata[8*i +: 8];
    end

    // Load data: selected lane zero-extended, faulty load reads zero
    logic [31:0] word;
    logic [31:0] shw;
    logic [31:0] rdata;

    assign word = mem[idx_q];
    assign shw  = word >> {lane_q, 3'b000};

    always_comb begin
        rdata = word;
        case (size_q)
            2'b00:   rdata = {24'd0, shw[7:0]};
            2'b01:   rdata = {16'd0, shw[15:0]};
            default: rdata = word;
        endcase
        if (fault_q)
            rdata = 32'd0;
    end

    // Outputs
    logic drive;

    always_comb begin
        ACKD_n = (state != S_ACK);
        drive  = (state == S_ACK) && !write_q;
`ifdef DMEM_ERR_EN
        ERR    = (state == S_ACK) && fault_q;
`endif
    end

    assign DDT = drive ? rdata : 32'bz;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: scoreboard bench for dmem_responder.
// Two instances (WAIT_CYCLES=2 and 0) against a word-array reference model.
module tb_dmem_responder;

    localparam int          DEPTH = 256;
    localparam int          WA    = 2;
    localparam int          WB    = 0;
    localparam logic [31:0] BA    = 32'h0000_0000;
    localparam logic [31:0] BB    = 32'h0000_0100;

    typedef struct {
        int          cyc;
        bit          ld;
        logic [31:0] data;
        bit          err;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mreq [2];
    logic        wr   [2];
    logic        tdrv [2];
    logic [31:0] dad  [2];
    logic [31:0] tdat [2];
    logic [1:0]  sz   [2];
    logic        ackn0, ackn1;
    logic        err0, err1;
    wire  [31:0] ddt0, ddt1;

    int vecs = 0;
    int miss = 0;
    int cyc  = 0;

    exp_t q0[$];
    exp_t q1[$];
    logic [31:0] mm [2][DEPTH];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    assign ddt0 = tdrv[0] ? tdat[0] : 32'bz;
    assign ddt1 = tdrv[1] ? tdat[1] : 32'bz;

    dmem_responder #(
        .BASE_ADDR(BA), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WA)
    ) u_a (
        .clk(clk), .reset(reset), .DAD(dad[0]), .DDT(ddt0),
        .MREQ(mreq[0]), .WRITE(wr[0]), .SIZE(sz[0]), .ACKD_n(ackn0)
`ifdef DMEM_ERR_EN
        , .ERR(err0)
`endif
    );

    dmem_responder #(
        .BASE_ADDR(BB), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WB)
    ) u_b (
        .clk(clk), .reset(reset), .DAD(dad[1]), .DDT(ddt1),
        .MREQ(mreq[1]), .WRITE(wr[1]), .SIZE(sz[1]), .ACKD_n(ackn1)
`ifdef DMEM_ERR_EN
        , .ERR(err1)
`endif
    );

`ifndef DMEM_ERR_EN
    assign err0 = 1'b0;
    assign err1 = 1'b0;
`endif

    function automatic logic [31:0] base_of(int u);
        return (u == 0) ? BA : BB;
    endfunction

    function automatic int wait_of(int u);
        return (u == 0) ? WA : WB;
    endfunction

    // Reference model: plain byte-address arithmetic over a word array
    function automatic bit is_fault(int u, logic [31:0] a, logic [1:0] s);
        logic [31:0] off;
        off = a - base_of(u);
`ifdef DMEM_ERR_EN
        if (off >= 32'(4 * DEPTH)) return 1'b1;
        if (s == 2'd1 && off % 2 != 0) return 1'b1;
        if (s >= 2'd2 && off % 4 != 0) return 1'b1;
`endif
        return (off === 32'hx) ? 1'b1 : 1'b0;
    endfunction

    function automatic logic [31:0] model_load(int u, logic [31:0] a,
                                               logic [1:0] s);
        logic [31:0] off;
        logic [31:0] w;
        int          i;
        off = a - base_of(u);
        if (is_fault(u, a, s)) return 32'h0;
        i = int'((off / 4) % DEPTH);
        w = mm[u][i];
        case (s)
            2'd0:    return (w >> (8 * (off % 4))) & 32'hFF;
            2'd1:    return (w >> (16 * ((off / 2) % 2))) & 32'hFFFF;
            default: return w;
        endcase
    endfunction

    task automatic model_store(int u, logic [31:0] a, logic [1:0] s,
                               logic [31:0] d);
        logic [31:0] off;
        int          i;
        int          k;
        off = a - base_of(u);
        if (is_fault(u, a, s)) return;
        i = int'((off / 4) % DEPTH);
        case (s)
            2'd0: begin
                k = int'(off % 4);
                mm[u][i][8*k +: 8] = d[7:0];
            end
            2'd1: begin
                k = int'((off / 2) % 2);
                mm[u][i][16*k +: 16] = d[15:0];
            end
            default: mm[u][i] = d;
        endcase
    endtask

    task automatic push(int u, exp_t e);
        if (u == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic idle(int u, int n);
        mreq[u] = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Issue one request; with hold=0 the bus is scrambled until ACK
    task automatic req(int u, bit w, logic [31:0] a, logic [1:0] s,
                       logic [31:0] d, bit hold);
        exp_t e;
        int   ack;
        mreq[u] = 1'b1;
        wr[u]   = w;
        dad[u]  = a;
        sz[u]   = s;
        tdat[u] = d;
        tdrv[u] = w;
        ack     = cyc + 1 + wait_of(u);
        e.cyc   = ack;
        e.ld    = !w;
        e.err   = is_fault(u, a, s);
        e.data  = w ? 32'h0 : model_load(u, a, s);
        if (w) model_store(u, a, s, d);
        push(u, e);
        @(posedge clk);
        #1;
        tdrv[u] = 1'b0;
        while (cyc <= ack) begin
            if (!hold) begin
                mreq[u] = 1'($urandom % 2);
                wr[u]   = 1'($urandom % 2);
                dad[u]  = $urandom;
                sz[u]   = 2'($urandom % 4);
            end
            @(posedge clk);
            #1;
        end
        if (!hold) mreq[u] = 1'b0;
    endtask

    // Word store on instance 0 with reset pulsed dly cycles after capture
    task automatic abort_store(logic [31:0] a, logic [31:0] d, int dly);
        exp_t e;
        int   n;
        n       = cyc;
        mreq[0] = 1'b1;
        wr[0]   = 1'b1;
        dad[0]  = a;
        sz[0]   = 2'd2;
        tdat[0] = d;
        tdrv[0] = 1'b1;
        if (n + 1 + WA == n + 1 + dly) begin
            e.cyc  = n + 1 + WA;
            e.ld   = 1'b0;
            e.err  = 1'b0;
            e.data = 32'h0;
            push(0, e);
        end
        @(posedge clk);
        #1;
        tdrv[0] = 1'b0;
        mreq[0] = 1'b0;
        repeat (dly) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(0, 4);
    endtask

    task automatic fail(string name, int u, logic [31:0] got,
                        logic [31:0] want);
        miss++;
        $display("FAIL %s u%0d cyc %0d: got %h want %h",
                 name, u, cyc, got, want);
    endtask

    // Monitor: every cycle, ACK must appear exactly when the scoreboard says
    task automatic mon(int u, logic an, logic [31:0] d, logic e);
        exp_t x;
        bit   due;
        due = 1'b0;
        if (u == 0 && q0.size() > 0 && q0[0].cyc == cyc) begin
            x   = q0.pop_front();
            due = 1'b1;
        end
        if (u == 1 && q1.size() > 0 && q1[0].cyc == cyc) begin
            x   = q1.pop_front();
            due = 1'b1;
        end
        vecs++;
        if (due) begin
            if (an !== 1'b0) begin
                fail("ack_missing", u, 32'(an), 32'd0);
            end else begin
                if (x.ld) begin
                    vecs++;
                    if (d !== x.data) fail("load_data", u, d, x.data);
                end
`ifdef DMEM_ERR_EN
                vecs++;
                if (e !== x.err) fail("err_flag", u, 32'(e), 32'(x.err));
`endif
            end
        end else begin
            if (an !== 1'b1) fail("ack_spurious", u, 32'(an), 32'd1);
            if (!tdrv[u]) begin
                vecs++;
                if (!(d === 32'bz || d === 32'h0))
                    fail("ddt_not_z", u, d, 32'bz);
            end
            vecs++;
            if (e !== 1'b0) fail("err_idle", u, 32'(e), 32'd0);
        end
    endtask

    always @(negedge clk) begin
        mon(0, ackn0, ddt0, err0);
        mon(1, ackn1, ddt1, err1);
    end

    initial begin
        for (int u = 0; u < 2; u++) begin
            mreq[u] = 1'b0;
            wr[u]   = 1'b0;
            tdrv[u] = 1'b0;
            dad[u]  = 32'h0;
            tdat[u] = 32'h0;
            sz[u]   = 2'd0;
        end
        for (int i = 0; i < DEPTH; i++) begin
            mm[0][i] = 32'h0;
            mm[1][i] = 32'h0;
        end
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        idle(0, 5);

        for (int i = 0; i < DEPTH; i++)
            req(0, 1'b1, BA + 32'(4 * i), 2'd2, $urandom, 1'b0);
        for (int i = 0; i < 16; i++)
            req(1, 1'b1, BB + 32'(4 * i), 2'd2, $urandom, 1'b0);
        idle(1, 1);

        req(0, 1'b1, 32'h10, 2'd2, 32'hDEAD_BEEF, 1'b0);
        req(0, 1'b0, 32'h10, 2'd2, 32'h0, 1'b0);
        req(0, 1'b1, 32'h10, 2'd2, 32'h1122_3344, 1'b0);
        req(0, 1'b1, 32'h13, 2'd0, 32'hFFFF_FFA5, 1'b0);
        req(0, 1'b0, 32'h10, 2'd2, 32'h0, 1'b0);
        req(0, 1'b0, 32'h12, 2'd1, 32'h0, 1'b0);
        req(0, 1'b0, 32'h11, 2'd0, 32'h0, 1'b0);
        idle(0, 2);

        abort_store(32'h20, 32'hCAFE_F00D, 0);
        abort_store(32'h20, 32'h0BAD_0BAD, WA);
        req(0, 1'b0, 32'h20, 2'd2, 32'h0, 1'b0);

        reset   = 1'b1;
        mreq[0] = 1'b1;
        wr[0]   = 1'b0;
        dad[0]  = 32'h10;
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(0, 5);

`ifdef DMEM_ERR_EN
        req(0, 1'b1, 32'h21, 2'd1, 32'h0000_FFFF, 1'b0);
        req(0, 1'b0, 32'h20, 2'd2, 32'h0, 1'b0);
        req(0, 1'b0, BA + 32'(4 * DEPTH), 2'd2, 32'h0, 1'b0);
        req(0, 1'b1, 32'h13, 2'd2, 32'h1234_5678, 1'b0);
`else
        req(0, 1'b0, 32'h22, 2'd2, 32'h0, 1'b0);
        req(0, 1'b0, BA + 32'(4 * DEPTH) + 32'h20, 2'd2, 32'h0, 1'b0);
        req(0, 1'b1, 32'h13, 2'd1, 32'h0000_7E57, 1'b0);
        req(0, 1'b0, 32'h10, 2'd2, 32'h0, 1'b0);
`endif
        idle(0, 2);

        for (int i = 0; i < 4; i++)
            req(1, 1'b0, BB + 32'(4 * i), 2'd2, 32'h0, 1'b1);
        idle(1, 4);

        for (int i = 0; i < 300; i++) begin
            req(0, 1'($urandom % 2), $urandom % (8 * DEPTH),
                2'($urandom % 4), $urandom, 1'b0);
            idle(0, int'($urandom % 3));
        end
        for (int i = 0; i < 100; i++) begin
            req(1, 1'($urandom % 2), BB + ($urandom % 64),
                2'($urandom % 4), $urandom, 1'($urandom % 2));
            if ($urandom % 2 == 0) idle(1, int'($urandom % 3));
        end
        idle(1, 1);
        idle(0, 6);

        vecs++;
        if (q0.size() + q1.size() != 0)
            fail("queue_drain", 0, 32'(q0.size() + q1.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule
